// File: rtl/fixp_acc_sched.sv
// Round-robin job scheduler that shares one fp64 accumulator among N_REQ requesters.
// Each granted job clears the accumulator, streams its beats through, and returns only the final sum.
module fixp_acc_sched #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 16,
    parameter int DW    = 64,
    localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*LEN_W-1:0] req_len_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ-1:0]       in_valid_i,
    input  logic [N_REQ*DW-1:0]    in_data_i,
    output logic [N_REQ-1:0]       in_ready_o,
    output logic                   acc_clr_valid_o,
    input  logic                   acc_clr_ready_i,
    output logic                   acc_in_valid_o,
    output logic [DW-1:0]          acc_in_data_o,
    input  logic                   acc_in_ready_i,
    input  logic                   acc_sum_valid_i,
    input  logic [DW-1:0]          acc_sum_data_i,
    output logic                   acc_sum_ready_o,
    output logic [N_REQ-1:0]       sum_valid_o,
    output logic [DW-1:0]          sum_data_o,
    input  logic [N_REQ-1:0]       sum_ready_i,
    output logic                   busy_o,
    output logic [GW-1:0]          grant_id_o
);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESP} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    ptr_q, ptr_d, gnt_q, gnt_d;
    logic [LEN_W-1:0] len_q, len_d, inCnt_q, inCnt_d, sumCnt_q, sumCnt_d;
    logic [DW-1:0]    sum_q, sum_d;

    logic             reqFound;
    logic [GW-1:0]    reqPick;
    logic             inFire, sumFire, lastIn, lastSum;
    logic [LEN_W-1:0] inCntInc, sumCntNext;

    // First pending requester at or after the pointer, wrapping around.
    always_comb begin
        reqFound = 1'b0;
        reqPick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!reqFound && req_valid_i[(int'(ptr_q) + k) % N_REQ]) begin
                reqFound = 1'b1;
                reqPick  = GW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign inFire     = (state_q == STREAM) && in_valid_i[gnt_q] && acc_in_ready_i;
    assign sumFire    = ((state_q == STREAM) || (state_q == DRAIN)) && acc_sum_valid_i;
    assign inCntInc   = inCnt_q + 1'b1;
    assign sumCntNext = sumFire ? sumCnt_q + 1'b1 : sumCnt_q;
    assign lastIn     = inFire && (inCntInc == len_q);
    // The final sum may land in the same cycle as the last beat, so look at next-state counts.
    assign lastSum    = sumFire && (sumCntNext == len_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reqFound) state_d = CLEAR;
            CLEAR:   if (acc_clr_ready_i) state_d = (len_q == '0) ? RESP : STREAM;
            STREAM:  if (lastIn) state_d = lastSum ? RESP : DRAIN;
            DRAIN:   if (lastSum) state_d = RESP;
            RESP:    if (sum_ready_i[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        len_d    = len_q;
        inCnt_d  = inCnt_q;
        sumCnt_d = sumCnt_q;
        sum_d    = sum_q;
        case (state_q)
            IDLE: begin
                if (reqFound) begin
                    gnt_d    = reqPick;
                    len_d    = req_len_i[int'(reqPick)*LEN_W +: LEN_W];
                    inCnt_d  = '0;
                    sumCnt_d = '0;
                    sum_d    = '0;
                end
            end
            STREAM, DRAIN: begin
                if (inFire) inCnt_d = inCntInc;
                sumCnt_d = sumCntNext;
                if (lastSum) sum_d = acc_sum_data_i;
            end
            RESP: begin
                if (sum_ready_i[gnt_q]) begin
                    ptr_d = (int'(gnt_q) == N_REQ-1) ? '0 : gnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            gnt_q    <= '0;
            len_q    <= '0;
            inCnt_q  <= '0;
            sumCnt_q <= '0;
            sum_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            len_q    <= len_d;
            inCnt_q  <= inCnt_d;
            sumCnt_q <= sumCnt_d;
            sum_q    <= sum_d;
        end
    end

    always_comb begin
        req_ready_o     = '0;
        in_ready_o      = '0;
        acc_clr_valid_o = 1'b0;
        acc_in_valid_o  = 1'b0;
        acc_in_data_o   = '0;
        acc_sum_ready_o = 1'b0;
        sum_valid_o     = '0;
        case (state_q)
            IDLE:   if (reqFound) req_ready_o[reqPick] = 1'b1;
            CLEAR:  acc_clr_valid_o = 1'b1;
            STREAM: begin
                acc_in_valid_o    = in_valid_i[gnt_q];
                acc_in_data_o     = in_data_i[int'(gnt_q)*DW +: DW];
                in_ready_o[gnt_q] = acc_in_ready_i;
                acc_sum_ready_o   = 1'b1;
            end
            DRAIN:  acc_sum_ready_o = 1'b1;
            RESP:   sum_valid_o[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign grant_id_o = gnt_q;
    assign sum_data_o = sum_q;

endmodule

// File: tb/tb_fixp_acc_sched.sv
// Scoreboard bench for fixp_acc_sched: requesters and an fp64 accumulator are modelled with reals,
// expected final sums are queued at grant time and checked by an independent monitor.
module tb_fixp_acc_sched;
    localparam int N  = 4;
    localparam int LW = 16;
    localparam int DW = 64;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    req_valid, req_ready, in_valid, in_ready, sum_valid, sum_ready;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] in_data;
    logic            acc_clr_valid, acc_clr_ready, acc_in_valid, acc_in_ready;
    logic            acc_sum_valid, acc_sum_ready, busy;
    logic [DW-1:0]   acc_in_data, acc_sum_data, sum_data;
    logic [GW-1:0]   grant_id;

    always #5 clk = ~clk;

    fixp_acc_sched #(.N_REQ(N), .LEN_W(LW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_len_i(req_len), .req_ready_o(req_ready),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .acc_clr_valid_o(acc_clr_valid), .acc_clr_ready_i(acc_clr_ready),
        .acc_in_valid_o(acc_in_valid), .acc_in_data_o(acc_in_data), .acc_in_ready_i(acc_in_ready),
        .acc_sum_valid_i(acc_sum_valid), .acc_sum_data_i(acc_sum_data), .acc_sum_ready_o(acc_sum_ready),
        .sum_valid_o(sum_valid), .sum_data_o(sum_data), .sum_ready_i(sum_ready),
        .busy_o(busy), .grant_id_o(grant_id)
    );

    typedef struct { int id; logic [63:0] sum; int len; } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        expQ[$];
    int          jobQ[N][$];
    real         beatBuf[N][$];
    bit          active[N];
    int          beatIdx[N];
    bit          inHeld[N];
    int          holdCnt[N];
    int          ptrModel;
    int          grantLog[$];
    logic [63:0] monLastSum;

    real         accReal, accPend;
    int          accBeats, clrCnt, clrWait;
    logic [63:0] sumQ[$];
    logic        dlySumValid;
    logic [63:0] dlySumData;
    bit          respNext;
    int          respOwner;

    bit zeroLat;
    int inRdyPct, inValPct, sumRdyPct, clrDelay, abortAfter;
    int sumHold[N];
    bit seqBeats;

    // Zero-latency accumulator answers combinationally; otherwise sums come from a queue one cycle later.
    assign acc_sum_valid = zeroLat ? (acc_in_valid & acc_in_ready) : dlySumValid;
    assign acc_sum_data  = zeroLat ? $realtobits(accReal + $bitstoreal(acc_in_data)) : dlySumData;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic anyActive();
        for (int i = 0; i < N; i++) if (active[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit allDone();
        for (int i = 0; i < N; i++) if (jobQ[i].size() != 0 || active[i]) return 1'b0;
        return (expQ.size() == 0);
    endfunction

    function automatic int rrPick();
        for (int k = 0; k < N; k++) if (req_valid[(ptrModel + k) % N]) return (ptrModel + k) % N;
        return -1;
    endfunction

    task automatic driveIdle();
        req_valid = '0; req_len = '0; in_valid = '0; in_data = '0; sum_ready = '0;
        acc_clr_ready = 1'b0; acc_in_ready = 1'b0; dlySumValid = 1'b0; dlySumData = '0;
    endtask

    task automatic clearModel();
        for (int i = 0; i < N; i++) begin
            jobQ[i].delete(); beatBuf[i].delete();
            active[i] = 0; beatIdx[i] = 0; inHeld[i] = 0; holdCnt[i] = 0;
        end
        expQ.delete(); sumQ.delete(); grantLog.delete();
        accReal = 0.0; accPend = 0.0; accBeats = 0; clrCnt = 0; clrWait = 0;
        ptrModel = 0; respNext = 0; respOwner = 0; monLastSum = '1;
    endtask

    task automatic setDefaults();
        zeroLat = 0; inRdyPct = 100; inValPct = 100; sumRdyPct = 100;
        clrDelay = 0; seqBeats = 0; abortAfter = -1;
        for (int i = 0; i < N; i++) sumHold[i] = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 0);
        chk({tag, "_in_ready"}, 64'(in_ready), 0);
        chk({tag, "_acc_clr_valid"}, 64'(acc_clr_valid), 0);
        chk({tag, "_acc_in_valid"}, 64'(acc_in_valid), 0);
        chk({tag, "_acc_in_data"}, acc_in_data, 0);
        chk({tag, "_acc_sum_ready"}, 64'(acc_sum_ready), 0);
        chk({tag, "_sum_valid"}, 64'(sum_valid), 0);
        chk({tag, "_sum_data"}, sum_data, 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_grant_id"}, 64'(grant_id), 0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        driveIdle();
        clearModel();
        repeat (2) @(negedge clk);
        #1 checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Stimulus runs at the falling edge; everything seen #1 later is what the next rising edge commits.
    task automatic applyStimulus(input string tag, input int budget);
        int cyc = 0;
        bit doAbort = 0;
        while (!allDone() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            accReal = accPend;
            if (doAbort) begin
                rst = 1'b1;
                driveIdle();
                #1 checkResetOutputs("abort");
                clearModel();
                @(negedge clk);
                rst = 1'b0;
                abortAfter = -1;
                return;
            end
            chk({tag, "_busy"}, 64'(busy), 64'(anyActive()));
            if (respNext) begin
                chk({tag, "_resp_next_cycle"}, 64'(sum_valid[respOwner]), 1);
                respNext = 0;
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i] = !active[i] && (jobQ[i].size() != 0);
                req_len[i*LW +: LW] = req_valid[i] ? LW'(jobQ[i][0]) : '0;
                if (active[i] && beatIdx[i] < beatBuf[i].size()) begin
                    if (!inHeld[i]) in_valid[i] = ($urandom_range(1, 100) <= inValPct);
                    in_data[i*DW +: DW] = $realtobits(beatBuf[i][beatIdx[i]]);
                end else begin
                    in_valid[i] = 1'b0;
                    in_data[i*DW +: DW] = '0;
                end
                holdCnt[i] = sum_valid[i] ? holdCnt[i] + 1 : 0;
                sum_ready[i] = (holdCnt[i] > sumHold[i]) && ($urandom_range(1, 100) <= sumRdyPct);
            end
            acc_in_ready = ($urandom_range(1, 100) <= inRdyPct);
            clrWait = acc_clr_valid ? clrWait + 1 : 0;
            acc_clr_ready = (clrWait > clrDelay);
            dlySumValid = (sumQ.size() != 0);
            dlySumData = (sumQ.size() != 0) ? sumQ[0] : '0;
            #1;
            checkOutput(tag, doAbort);
        end
        if (!allDone()) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: jobs still outstanding after %0d cycles, expected none", tag, budget);
            clearModel();
        end
    endtask

    task automatic checkOutput(input string tag, inout bit doAbort);
        int g;
        logic [N-1:0] ownerMask;
        accPend = accReal;
        ownerMask = '0;
        for (int i = 0; i < N; i++) ownerMask[i] = active[i];
        chk({tag, "_in_ready_nonowner"}, 64'(in_ready & ~ownerMask), 0);
        chk({tag, "_req_ready_without_valid"}, 64'(req_ready & ~req_valid), 0);
        if ((req_valid & req_ready) != '0) begin
            chk({tag, "_req_ready_onehot"}, 64'($countones(req_ready)), 1);
            g = rrPick();
            for (int i = 0; i < N; i++) if (req_valid[i] & req_ready[i]) begin
                real s = 0.0;
                int len = jobQ[i].pop_front();
                chk({tag, "_grant_order"}, 64'(i), 64'(g));
                grantLog.push_back(i);
                beatBuf[i].delete();
                for (int k = 0; k < len; k++) begin
                    real v = seqBeats ? real'(k + 1) : real'(int'($urandom_range(0, 32)) - 16) * 0.5;
                    beatBuf[i].push_back(v);
                    s = s + v;
                end
                expQ.push_back('{i, $realtobits(s), len});
                active[i] = 1; beatIdx[i] = 0; inHeld[i] = 0;
                clrCnt = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] & in_ready[i]) begin
                beatIdx[i]++;
                inHeld[i] = 0;
                if (zeroLat && beatIdx[i] == beatBuf[i].size()) begin
                    respNext = 1; respOwner = i;
                end
                if (abortAfter >= 0 && beatIdx[i] == abortAfter) doAbort = 1;
            end else begin
                inHeld[i] = in_valid[i];
            end
        end
        if (acc_clr_valid & acc_clr_ready) begin
            accPend = 0.0; accBeats = 0; clrCnt++; sumQ.delete();
        end
        if (!zeroLat && dlySumValid && acc_sum_ready) void'(sumQ.pop_front());
        if (acc_in_valid & acc_in_ready) begin
            accPend = accPend + $bitstoreal(acc_in_data);
            accBeats++;
            if (!zeroLat) sumQ.push_back($realtobits(accPend));
        end
        for (int i = 0; i < N; i++) if (sum_valid[i] & sum_ready[i]) begin
            active[i] = 0;
            ptrModel = (i + 1) % N;
        end
    endtask

    // Independent monitor: pops the scoreboard whenever a final sum is handed over.
    initial begin
        bit prevHeld = 0;
        logic [63:0] prevData = '0;
        logic [N-1:0] prevVld = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst || sum_valid == '0) begin
                prevHeld = 0;
                continue;
            end
            if (prevHeld) begin
                chk("sum_data_stable", sum_data, prevData);
                chk("sum_valid_stable", 64'(sum_valid), 64'(prevVld));
            end
            chk("busy_in_resp", 64'(busy), 1);
            if ((sum_valid & sum_ready) != '0) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_sum: got sum_valid=%b expected no response", sum_valid);
                end else begin
                    e = expQ.pop_front();
                    chk("sum_owner", 64'(sum_valid), 64'(1) << e.id);
                    chk("sum_data", sum_data, e.sum);
                    chk("grant_id", 64'(grant_id), 64'(e.id));
                    chk("acc_beats", 64'(accBeats), 64'(e.len));
                    chk("clr_count", 64'(clrCnt), 1);
                    monLastSum = sum_data;
                end
                prevHeld = 0;
            end else begin
                prevHeld = 1;
                prevData = sum_data;
                prevVld = sum_valid;
            end
        end
    end

    initial begin
        int expOrder2[5] = '{0, 1, 2, 3, 0};
        int expOrder6[2] = '{0, 3};
        setDefaults();
        applyReset();

        $display("[TB] single job, beats 1..4");
        seqBeats = 1;
        jobQ[0].push_back(4);
        applyStimulus("t1", 500);
        chk("t1_sum_ten", monLastSum, 64'h4024000000000000);

        $display("[TB] four simultaneous requests");
        applyReset();
        setDefaults();
        for (int i = 0; i < N; i++) jobQ[i].push_back(2);
        jobQ[0].push_back(2);
        applyStimulus("t2", 1000);
        for (int k = 0; k < 5; k++)
            chk("t2_grant_sequence", 64'(grantLog.size() > k ? grantLog[k] : -1), 64'(expOrder2[k]));

        $display("[TB] zero-length job");
        applyReset();
        setDefaults();
        jobQ[2].push_back(0);
        applyStimulus("t3", 200);
        chk("t3_zero_sum", monLastSum, 0);

        $display("[TB] backpressure");
        applyReset();
        setDefaults();
        inRdyPct = 50; clrDelay = 5; sumHold[1] = 10;
        jobQ[1].push_back(6);
        jobQ[3].push_back(3);
        applyStimulus("t4", 1000);

        $display("[TB] zero-latency accumulator");
        applyReset();
        setDefaults();
        zeroLat = 1;
        jobQ[1].push_back(3);
        jobQ[2].push_back(1);
        applyStimulus("t5", 500);

        $display("[TB] reset mid-stream");
        applyReset();
        setDefaults();
        abortAfter = 2;
        jobQ[2].push_back(5);
        applyStimulus("t6a", 200);
        setDefaults();
        jobQ[0].push_back(3);
        jobQ[3].push_back(2);
        applyStimulus("t6b", 500);
        for (int k = 0; k < 2; k++)
            chk("t6_grant_sequence", 64'(grantLog.size() > k ? grantLog[k] : -1), 64'(expOrder6[k]));

        $display("[TB] randomized traffic");
        for (int b = 0; b < 5; b++) begin
            setDefaults();
            zeroLat = $urandom_range(0, 1);
            inRdyPct = $urandom_range(30, 100);
            inValPct = $urandom_range(30, 100);
            sumRdyPct = $urandom_range(40, 100);
            clrDelay = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) sumHold[i] = $urandom_range(0, 3);
            for (int j = 0; j < 6; j++) jobQ[$urandom_range(0, N-1)].push_back(int'($urandom_range(0, 6)));
            applyStimulus("rand", 3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
